// File: rtl/mult_accum_seq.sv
// Group accumulator for signed multiplier products.
// Sums LEN products per group and hands the total out on a valid/ready port.
module mult_accum_seq #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic             acc_in;
    logic             acc_out;
    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic             first;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;

    assign in_ready = !rst && ((state == ACCUM) || out_ready);
    assign acc_in   = in_valid & in_ready;
    assign acc_out  = out_valid & out_ready;

    assign operand = ACC_W'($signed(in_product));
    assign sum     = acc + operand;
    assign add_ovf = (acc[ACC_W-1] == operand[ACC_W-1])
                  && (sum[ACC_W-1] != acc[ACC_W-1]);

    // cnt is zero in HOLD, so a product taken there always opens a group
    assign first   = (cnt == '0);
    assign acc_nxt = first ? operand : sum;
    assign ovf_nxt = first ? 1'b0 : (ovf | add_ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            cnt          <= '0;
            acc          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (acc_in) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
            end
            unique case (state)
                ACCUM: begin
                    if (acc_in) begin
                        if (cnt == LAST) begin
                            state        <= HOLD;
                            cnt          <= '0;
                            out_valid    <= 1'b1;
                            out_sum      <= acc_nxt;
                            out_overflow <= ovf_nxt;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (acc_out) begin
                        if (acc_in && (LEN == 1)) begin
                            out_sum      <= acc_nxt;
                            out_overflow <= ovf_nxt;
                        end else if (acc_in) begin
                            state     <= ACCUM;
                            cnt       <= CNT_W'(1);
                            out_valid <= 1'b0;
                        end else begin
                            state     <= ACCUM;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accum_seq.sv
// Bench for mult_accum_seq: three configurations driven by shared stimulus,
// checked every cycle against a group-sum model plus directed literals.
module tb_mult_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        out_ready;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  ovfl;
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [15:0] sum2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_accum_seq #(.PROD_W(8), .ACC_W(16), .LEN(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_product(in_product), .out_valid(vld[0]), .out_ready(out_ready),
        .out_sum(sum0), .out_overflow(ovfl[0])
    );

    mult_accum_seq #(.PROD_W(8), .ACC_W(8), .LEN(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_product(in_product), .out_valid(vld[1]), .out_ready(out_ready),
        .out_sum(sum1), .out_overflow(ovfl[1])
    );

    mult_accum_seq #(.PROD_W(8), .ACC_W(16), .LEN(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_product(in_product), .out_valid(vld[2]), .out_ready(out_ready),
        .out_sum(sum2), .out_overflow(ovfl[2])
    );

    int d_sum [3];
    always_comb begin
        d_sum[0] = int'($signed(sum0));
        d_sum[1] = int'($signed(sum1));
        d_sum[2] = int'($signed(sum2));
    end

    // Model: running signed sum per group, wrapped to the accumulator width
    int LENS [3] = '{4, 2, 1};
    int WS   [3] = '{16, 8, 16};
    int m_cnt   [3] = '{0, 0, 0};
    int m_acc   [3] = '{0, 0, 0};
    int m_gov   [3] = '{0, 0, 0};
    int m_valid [3] = '{0, 0, 0};
    int m_sum   [3] = '{0, 0, 0};
    int m_ovf   [3] = '{0, 0, 0};

    function automatic int wrap(int s, int w);
        int t;
        t = s <<< (32 - w);
        return t >>> (32 - w);
    endfunction

    function automatic int m_rdy(int i);
        return (!rst && (m_valid[i] == 0 || out_ready)) ? 1 : 0;
    endfunction

    task automatic chk(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        int ai, p, s;
        for (int i = 0; i < 3; i++) begin
            ai = in_valid && m_rdy(i) != 0;
            if (rst) begin
                m_cnt[i] = 0; m_acc[i] = 0; m_gov[i] = 0;
                m_valid[i] = 0; m_sum[i] = 0; m_ovf[i] = 0;
            end else begin
                if (m_valid[i] != 0 && out_ready) m_valid[i] = 0;
                if (ai != 0) begin
                    p = int'($signed(in_product));
                    if (m_cnt[i] == 0) begin
                        m_acc[i] = p;
                        m_gov[i] = 0;
                    end else begin
                        s = m_acc[i] + p;
                        if (s != wrap(s, WS[i])) m_gov[i] = 1;
                        m_acc[i] = wrap(s, WS[i]);
                    end
                    m_cnt[i]++;
                    if (m_cnt[i] == LENS[i]) begin
                        m_cnt[i] = 0;
                        m_valid[i] = 1;
                        m_sum[i] = m_acc[i];
                        m_ovf[i] = m_gov[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if ($time > 6) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d in_ready", i), int'(rdy[i]), m_rdy(i));
                chk($sformatf("u%0d out_valid", i), int'(vld[i]), m_valid[i]);
                if (m_valid[i] != 0) begin
                    chk($sformatf("u%0d out_sum", i), d_sum[i], m_sum[i]);
                    chk($sformatf("u%0d out_ovf", i), int'(ovfl[i]), m_ovf[i]);
                end
            end
        end
    end

    task automatic set_in(input logic v, input int p, input logic r);
        in_valid   = v;
        in_product = p[7:0];
        out_ready  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 0, 1'b1);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 0, 1'b1);
        tick();
        tick();
        chk("rst in_ready", int'(rdy), 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", int'(rdy), 7);
        chk("post-rst out_valid", int'(vld), 0);
        chk("post-rst sum0", d_sum[0], 0);
        chk("post-rst ovf", int'(ovfl), 0);

        // Full-rate group and overflow in the 8-bit accumulator
        do_reset();
        set_in(1'b1, 64, 1'b1); tick();
        set_in(1'b1, 64, 1'b1); tick();
        chk("A u1 sum", d_sum[1], -128);
        chk("A u1 ovf", int'(ovfl[1]), 1);
        chk("A u1 model ovf", m_ovf[1], 1);
        set_in(1'b1, -56, 1'b1); tick();
        chk("A u2 sum", d_sum[2], -56);
        set_in(1'b1, 7, 1'b1); tick();
        chk("A u0 valid", int'(vld[0]), 1);
        chk("A u0 sum", d_sum[0], 79);
        chk("A u0 ovf", int'(ovfl[0]), 0);
        chk("A u0 model sum", m_sum[0], 79);
        set_in(1'b1, 1, 1'b1);
        #1;
        chk("A u0 5th ready", int'(rdy[0]), 1);
        tick();
        chk("A u0 valid after", int'(vld[0]), 0);

        // Overflow flag clears with the next group
        do_reset();
        set_in(1'b1, 64, 1'b1); tick();
        set_in(1'b1, 64, 1'b1); tick();
        set_in(1'b1, 1, 1'b1); tick();
        set_in(1'b1, 1, 1'b1); tick();
        chk("B u1 sum", d_sum[1], 2);
        chk("B u1 ovf", int'(ovfl[1]), 0);

        // LEN=1 back-to-back
        do_reset();
        set_in(1'b1, -8, 1'b1); tick();
        chk("C u2 v0", int'(vld[2]), 1);
        chk("C u2 s0", d_sum[2], -8);
        set_in(1'b1, 15, 1'b1); tick();
        chk("C u2 v1", int'(vld[2]), 1);
        chk("C u2 s1", d_sum[2], 15);
        set_in(1'b1, 0, 1'b1); tick();
        chk("C u2 v2", int'(vld[2]), 1);
        chk("C u2 s2", d_sum[2], 0);
        set_in(1'b0, 0, 1'b1); tick();
        chk("C u2 idle", int'(vld[2]), 0);

        // Backpressure
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, k, 1'b0); tick();
        end
        chk("D u0 valid", int'(vld[0]), 1);
        chk("D u0 sum", d_sum[0], 10);
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 100, 1'b0);
            #1;
            chk("D u0 stall ready", int'(rdy[0]), 0);
            tick();
            chk("D u0 held sum", d_sum[0], 10);
        end
        set_in(1'b1, 5, 1'b1);
        #1;
        chk("D u0 release ready", int'(rdy[0]), 1);
        tick();
        chk("D u0 valid drop", int'(vld[0]), 0);
        for (int k = 6; k <= 8; k++) begin
            set_in(1'b1, k, 1'b1); tick();
        end
        chk("D u0 valid2", int'(vld[0]), 1);
        chk("D u0 sum2", d_sum[0], 26);

        // Reset mid-group
        do_reset();
        set_in(1'b1, 9, 1'b1); tick();
        set_in(1'b1, 9, 1'b1); tick();
        rst = 1'b1;
        set_in(1'b1, 50, 1'b1);
        #1;
        chk("E rst ready", int'(rdy), 0);
        tick();
        chk("E rst valid", int'(vld), 0);
        chk("E rst sum0", d_sum[0], 0);
        chk("E rst ovf", int'(ovfl), 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1, 1'b1); tick();
        end
        chk("E u0 valid", int'(vld[0]), 1);
        chk("E u0 sum", d_sum[0], 4);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 14000; k++) begin
            set_in($urandom_range(0, 99) < 80,
                   int'($urandom_range(0, 120)) - 56,
                   $urandom_range(0, 99) < 70);
            tick();
        end
        set_in(1'b0, 0, 1'b1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
